ann_layer_sequencer: RTL

- FSM controller that runs the three fully connected layers of the classifier one at a time, instead of streaming all three together from one free-running address counter.
- Drives the shared weight-memory address, per-layer enable and reset, and per-stage ReLU enable and reset.
- Captures the FindMax class result and signals completion with a start/done handshake.
- Sits between the CNN feature-extraction front end and the FC datapath (weight memories, layers, activation functions, FindMax).

---
 rtl/ann_layer_sequencer.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/ann_layer_sequencer.sv
// Sequencer that runs the three fully connected layers one after another and captures the FindMax class.
// Optional abort path is built in when ANN_SEQ_ABORT_EN is defined.
module ann_layer_sequencer #(
  parameter int INPUT_NODES_L1 = 400,
  parameter int INPUT_NODES_L2 = 120,
  parameter int INPUT_NODES_L3 = 84,
  parameter int ADDR_WIDTH     = 9,
  parameter int DRAIN_CYCLES   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  ready,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [2:0]            layer_en,
  output logic [2:0]            rst_layer,
  output logic                  rst_relu,
  output logic [1:0]            en_relu,
  input  logic [3:0]            class_in,
  output logic [3:0]            class_out,
`ifdef ANN_SEQ_ABORT_EN
  input  logic                  abort,
  output logic                  aborted,
`endif
  output logic                  done
);

  typedef enum logic [3:0] {
    IDLE,
    L1_RUN,
    L1_DRAIN,
    RELU1,
    L2_RUN,
    L2_DRAIN,
    RELU2,
    L3_RUN,
    L3_DRAIN,
    CAPTURE
  } state_t;

  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST =
    DRAIN_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  localparam logic [ADDR_WIDTH-1:0] L1_LAST = ADDR_WIDTH'(INPUT_NODES_L1 - 1);
  localparam logic [ADDR_WIDTH-1:0] L2_LAST = ADDR_WIDTH'(INPUT_NODES_L2 - 1);
  localparam logic [ADDR_WIDTH-1:0] L3_LAST = ADDR_WIDTH'(INPUT_NODES_L3 - 1);

  state_t                 state;
  state_t                 state_d;
  state_t                 drain_st;
  state_t                 post_st;
  logic [ADDR_WIDTH-1:0]  address_d;
  logic [ADDR_WIDTH-1:0]  run_last;
  logic [DRAIN_W-1:0]     drain_cnt;
  logic [DRAIN_W-1:0]     drain_d;
  logic                   done_d;
  logic [3:0]             class_d;
`ifdef ANN_SEQ_ABORT_EN
  logic                   aborted_d;
`endif

  // Per-layer constants for whichever layer the current state belongs to.
  always_comb begin
    run_last = '0;
    drain_st = IDLE;
    post_st  = IDLE;
    case (state)
      L1_RUN, L1_DRAIN: begin
        run_last = L1_LAST;
        drain_st = L1_DRAIN;
        post_st  = RELU1;
      end
      L2_RUN, L2_DRAIN: begin
        run_last = L2_LAST;
        drain_st = L2_DRAIN;
        post_st  = RELU2;
      end
      L3_RUN, L3_DRAIN: begin
        run_last = L3_LAST;
        drain_st = L3_DRAIN;
        post_st  = CAPTURE;
      end
      default: begin
        run_last = '0;
        drain_st = IDLE;
        post_st  = IDLE;
      end
    endcase
  end

  always_comb begin
    state_d   = state;
    address_d = address;
    drain_d   = drain_cnt;
    done_d    = 1'b0;
    class_d   = class_out;
`ifdef ANN_SEQ_ABORT_EN
    aborted_d = 1'b0;
`endif
    case (state)
      IDLE: begin
        address_d = '0;
        drain_d   = '0;
        if (start) begin
          state_d = L1_RUN;
        end
      end
      L1_RUN, L2_RUN, L3_RUN: begin
        // The last row is detected before incrementing so the counter never wraps.
        if (address == run_last) begin
          if (DRAIN_CYCLES == 0) begin
            state_d   = post_st;
            address_d = '0;
          end else begin
            state_d = drain_st;
            drain_d = '0;
          end
        end else begin
          address_d = address + 1'b1;
        end
      end
      L1_DRAIN, L2_DRAIN, L3_DRAIN: begin
        if (DRAIN_CYCLES == 0 || drain_cnt == DRAIN_LAST) begin
          state_d   = post_st;
          address_d = '0;
        end else begin
          drain_d = drain_cnt + 1'b1;
        end
      end
      RELU1: begin
        state_d = L2_RUN;
      end
      RELU2: begin
        state_d = L3_RUN;
      end
      CAPTURE: begin
        class_d = class_in;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        address_d = '0;
      end
    endcase
`ifdef ANN_SEQ_ABORT_EN
    if (abort && state != IDLE) begin
      state_d   = IDLE;
      address_d = '0;
      drain_d   = '0;
      done_d    = 1'b0;
      class_d   = class_out;
      aborted_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      address   <= '0;
      drain_cnt <= '0;
      done      <= 1'b0;
      class_out <= 4'd0;
`ifdef ANN_SEQ_ABORT_EN
      aborted   <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      address   <= address_d;
      drain_cnt <= drain_d;
      done      <= done_d;
      class_out <= class_d;
`ifdef ANN_SEQ_ABORT_EN
      aborted   <= aborted_d;
`endif
    end
  end

  // Control strobes are pure decodes of the registered state.
  always_comb begin
    layer_en = 3'b000;
    en_relu  = 2'b00;
    case (state)
      L1_RUN, L1_DRAIN: layer_en = 3'b001;
      L2_RUN, L2_DRAIN: layer_en = 3'b010;
      L3_RUN, L3_DRAIN: layer_en = 3'b100;
      RELU1:            en_relu  = 2'b01;
      RELU2:            en_relu  = 2'b10;
      default: begin
        layer_en = 3'b000;
        en_relu  = 2'b00;
      end
    endcase
  end

  assign ready     = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rst_layer = (state == IDLE) ? 3'b111 : 3'b000;
  assign rst_relu  = (state == IDLE);

endmodule
